debouncer: RTL
==============

// Module: debouncer
// PURPOSE
//   Filters the already-synchronized level from the synchronizer stage (its sync_out) for
//   mechanical bounce. Emits a clean level plus single-cycle press, release and long-press
//   ticks for downstream control logic such as mode FSMs and counters. All logic is in the
//   clk domain. Input is already metastability-safe, so no extra sync flops are used here.
// PARAMETERS
//   STABLE_CYCLES  1_000_000    consecutive identical samples needed to accept a new level (10 ms @ 100 MHz); >= 2
//   LONG_CYCLES    100_000_000  cycles db_out must stay high before long_press_tick fires (1 s @ 100 MHz); >= 1
//   CNT_W          $clog2(STABLE_CYCLES+1)  localparam, width of the stability counter
//   HOLD_W         $clog2(LONG_CYCLES+1)    localparam, width of the hold counter
// PORTS
//   clk              in   1  system clock; all state updates on rising edge
//   rst              in   1  synchronous, active-high reset
//   sync_in          in   1  synchronized raw level, connected to synchronizer sync_out
//   db_out           out  1  debounced level, registered
//   press_tick       out  1  1-cycle pulse on accepted 0->1 transition
//   release_tick     out  1  1-cycle pulse on accepted 1->0 transition
//   long_press_tick  out  1  1-cycle pulse after LONG_CYCLES of continuous db_out=1
// BEHAVIOUR
//   Reset (rst=1 at a clk edge): state=LOW, stab_cnt=0, hold_cnt=0, fired=0. All outputs are 0
//     from the next cycle. Reset overrides every transition in the same cycle.
//   FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW. db_out is 1 in HIGH and WAIT_LOW, else 0.
//   LOW:       sync_in=1 -> WAIT_HIGH with stab_cnt=1; else stay, stab_cnt=0.
//   WAIT_HIGH: sync_in=0 -> LOW, stab_cnt=0 (bounce rejected, no tick).
//              sync_in=1 and stab_cnt==STABLE_CYCLES-1 -> HIGH, stab_cnt=0, press_tick=1 same edge.
//              else stab_cnt+1.
//   HIGH:      sync_in=0 -> WAIT_LOW with stab_cnt=1; else stay.
//   WAIT_LOW:  sync_in=1 -> HIGH, stab_cnt=0 (no tick, hold_cnt unaffected).
//              sync_in=0 and stab_cnt==STABLE_CYCLES-1 -> LOW, release_tick=1 same edge.
//              else stab_cnt+1.
//   Latency: db_out and the tick change on the clk edge that samples the STABLE_CYCLES-th
//     consecutive new-level sample. The first new sample is counted as 1.
//   Ticks are registered, high for exactly one cycle, and mutually exclusive except
//     long_press_tick, which may coincide with no other tick (see below).
//   Hold counter: cleared on entry to HIGH from WAIT_HIGH. Increments every cycle db_out=1
//     and saturates at LONG_CYCLES. On the edge where it reaches LONG_CYCLES with fired=0:
//     long_press_tick=1 and fired=1. At most one long_press_tick per press.
//   fired and hold_cnt clear on accepted release (entry to LOW). The long press may fire
//     during WAIT_LOW if the threshold is reached before the release is accepted.
//   A long press is never reported for a pulse shorter than LONG_CYCLES after acceptance.
//   stab_cnt never exceeds STABLE_CYCLES-1 and never wraps; hold_cnt never wraps.
//   sync_in constant 0 from reset: outputs stay 0 forever.
//   Reset mid-press (db_out=1): db_out->0 next cycle, no release_tick emitted.
// TESTING (bench with STABLE_CYCLES=4, LONG_CYCLES=20, 100 MHz clk)
//   1 Reset: rst=1 for 2 cycles with sync_in=1 -> db_out and all ticks 0 during reset and on
//     the first cycle after. press_tick appears 4 edges after rst falls.
//   2 Clean press: sync_in 0->1 held -> db_out=1 and press_tick=1 on the 4th sampling edge.
//     press_tick low on the next cycle.
//   3 Bounce: sync_in 1,1,1,0,1,1,1,1 -> no tick after first three 1s. press_tick on the
//     4th 1 of the second run (edge 8).
//   4 Release bounce: from HIGH, sync_in 0,0,1,0,0,0,0 -> db_out stays 1 through the glitch.
//     release_tick and db_out=0 on the 7th edge.
//   5 Long press: hold sync_in=1 for 40 cycles -> long_press_tick exactly once, 20 cycles after
//     press_tick. No repeat. Release yields release_tick 4 edges after sync_in falls.
//   6 Reset mid-press: assert rst while db_out=1, 10 cycles after press -> db_out=0 next cycle.
//     No release_tick or long_press_tick afterwards with sync_in held 0.

Source files
------------

// File: rtl/debouncer.sv
// debouncer: filters an already-synchronized level for mechanical bounce and
// emits a clean registered level plus single-cycle press, release and
// long-press ticks. Everything lives in the clk domain.
module debouncer #(
   parameter int STABLE_CYCLES = 1_000_000,   // consecutive samples to accept a level, >= 2
   parameter int LONG_CYCLES   = 100_000_000  // cycles of db_out=1 before long press, >= 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sync_in,
   output logic       db_out,
   output logic       press_tick,
   output logic       release_tick,
   output logic       long_press_tick,
   output logic [1:0] dbg_state        // current FSM state, for observation only
);

   localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
   localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

   localparam logic [CNT_W-1:0]  STAB_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0]  STAB_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

   // db_out is 1 exactly in S_HIGH and S_WAIT_LOW
   typedef enum logic [1:0] {
      S_LOW       = 2'd0,
      S_WAIT_HIGH = 2'd1,
      S_HIGH      = 2'd2,
      S_WAIT_LOW  = 2'd3
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_stab_cnt;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic                r_fired;
   logic                r_db_out;
   logic                r_press_tick;
   logic                r_release_tick;
   logic                r_long_tick;

   state_t              w_state_nxt;
   logic [CNT_W-1:0]    w_stab_nxt;
   logic                w_press_nxt;
   logic                w_release_nxt;
   logic                w_db_nxt;
   logic [HOLD_W-1:0]   w_hold_nxt;
   logic [HOLD_W-1:0]   w_hold_inc;
   logic                w_fired_nxt;
   logic                w_long_nxt;

   // Next-state and stability counting: a new level is accepted on the edge
   // that samples its STABLE_CYCLES-th consecutive occurrence; any opposite
   // sample while waiting returns to the old stable state without a tick.
   always_comb begin
      w_state_nxt   = r_state;
      w_stab_nxt    = r_stab_cnt;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      case (r_state)
         S_LOW: begin
            if (sync_in) begin
               w_state_nxt = S_WAIT_HIGH;
               w_stab_nxt  = STAB_ONE;
            end else begin
               w_stab_nxt  = STAB_ZERO;
            end
         end
         S_WAIT_HIGH: begin
            if (!sync_in) begin
               w_state_nxt = S_LOW;
               w_stab_nxt  = STAB_ZERO;
            end else if (r_stab_cnt == STAB_LAST) begin
               w_state_nxt = S_HIGH;
               w_stab_nxt  = STAB_ZERO;
               w_press_nxt = 1'b1;
            end else begin
               w_stab_nxt  = r_stab_cnt + STAB_ONE;
            end
         end
         S_HIGH: begin
            if (!sync_in) begin
               w_state_nxt = S_WAIT_LOW;
               w_stab_nxt  = STAB_ONE;
            end
         end
         S_WAIT_LOW: begin
            if (sync_in) begin
               w_state_nxt = S_HIGH;
               w_stab_nxt  = STAB_ZERO;
            end else if (r_stab_cnt == STAB_LAST) begin
               w_state_nxt   = S_LOW;
               w_stab_nxt    = STAB_ZERO;
               w_release_nxt = 1'b1;
            end else begin
               w_stab_nxt    = r_stab_cnt + STAB_ONE;
            end
         end
         default: begin
            w_state_nxt = S_LOW;
            w_stab_nxt  = STAB_ZERO;
         end
      endcase
      w_db_nxt = (w_state_nxt == S_HIGH) || (w_state_nxt == S_WAIT_LOW);
   end

   // Hold counting: cleared on press and on release, otherwise counts while
   // db_out is high and saturates; the long tick fires once when the count
   // reaches LONG_CYCLES. Release wins, so long and release never coincide.
   always_comb begin
      w_hold_nxt  = r_hold_cnt;
      w_fired_nxt = r_fired;
      w_long_nxt  = 1'b0;
      w_hold_inc  = r_hold_cnt + HOLD_ONE;
      if (w_release_nxt) begin
         w_hold_nxt  = HOLD_ZERO;
         w_fired_nxt = 1'b0;
      end else if (w_press_nxt) begin
         w_hold_nxt  = HOLD_ZERO;
      end else if (r_db_out && (r_hold_cnt != HOLD_MAX)) begin
         w_hold_nxt = w_hold_inc;
         if ((w_hold_inc == HOLD_MAX) && !r_fired) begin
            w_long_nxt  = 1'b1;
            w_fired_nxt = 1'b1;
         end
      end
   end

   // State, counters and registered outputs; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_LOW;
         r_stab_cnt     <= STAB_ZERO;
         r_hold_cnt     <= HOLD_ZERO;
         r_fired        <= 1'b0;
         r_db_out       <= 1'b0;
         r_press_tick   <= 1'b0;
         r_release_tick <= 1'b0;
         r_long_tick    <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_stab_cnt     <= w_stab_nxt;
         r_hold_cnt     <= w_hold_nxt;
         r_fired        <= w_fired_nxt;
         r_db_out       <= w_db_nxt;
         r_press_tick   <= w_press_nxt;
         r_release_tick <= w_release_nxt;
         r_long_tick    <= w_long_nxt;
      end
   end

   assign db_out          = r_db_out;
   assign press_tick      = r_press_tick;
   assign release_tick    = r_release_tick;
   assign long_press_tick = r_long_tick;
   assign dbg_state       = r_state;

endmodule
